// File: rtl/shift_add_mult.sv
// Sequential 4x4 unsigned shift-and-add multiplier. It sequences an external
// combinational left shifter over the sh_* ports and accumulates its result.
module shift_add_mult #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sh_data,
  output logic [1:0] sh_sel,
  input  logic [6:0] sh_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [3:0] a_reg;
  logic [3:0] b_reg;
  logic [1:0] cnt;
  logic [7:0] acc;

  logic [3:0] rem_bits;
  logic       last_step;
  logic [7:0] acc_sum;

  // Multiplier bits above the current one; a shift by 4 at cnt=3 yields zero.
  assign rem_bits  = b_reg >> (3'(cnt) + 3'd1);
  assign last_step = (cnt == 2'd3) || (EARLY_EXIT && (rem_bits == 4'd0));
  assign acc_sum   = acc + {1'b0, sh_out};

  // sh_data/sh_sel are loaded one step ahead so they are registered yet
  // already show a_reg and cnt during every RUN cycle.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // clears every register here (none of these are memory arrays).
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      cnt     <= '0;
      acc     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sh_data <= '0;
      sh_sel  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            acc     <= '0;
            cnt     <= '0;
            sh_data <= a;
            sh_sel  <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (b_reg[cnt]) acc <= acc_sum;
          if (last_step) begin
            sh_data <= '0;
            sh_sel  <= '0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt    <= cnt + 2'd1;
            sh_sel <= cnt + 2'd1;
          end
        end
        DONE: begin
          product <= acc;
          done    <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult: one instance per EARLY_EXIT setting, each
// wired to a behavioural model of the 4-bit/2-bit-select left shifter.
module tb_shift_add_mult;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1;
  logic [3:0] a, b;

  logic [3:0] sh_data0, sh_data1;
  logic [1:0] sh_sel0, sh_sel1;
  logic [6:0] sh_out0, sh_out1;
  logic       busy0, busy1, done0, done1;
  logic [7:0] product0, product1;

  int errors = 0;
  int checks = 0;

  logic [7:0] last_p0 = 8'd0;
  logic [7:0] last_p1 = 8'd0;

  // Selects which instance the shared tasks observe.
  logic       cur = 1'b0;
  logic       c_busy, c_done;
  logic [1:0] c_sel;
  logic [3:0] c_data;
  logic [7:0] c_prod;

  always #5 clk = ~clk;

  assign sh_out0 = 7'({3'b000, sh_data0} << sh_sel0);
  assign sh_out1 = 7'({3'b000, sh_data1} << sh_sel1);

  assign c_busy = cur ? busy1    : busy0;
  assign c_done = cur ? done1    : done0;
  assign c_sel  = cur ? sh_sel1  : sh_sel0;
  assign c_data = cur ? sh_data1 : sh_data0;
  assign c_prod = cur ? product1 : product0;

  shift_add_mult #(.EARLY_EXIT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b),
    .sh_data(sh_data0), .sh_sel(sh_sel0), .sh_out(sh_out0),
    .busy(busy0), .done(done0), .product(product0)
  );

  shift_add_mult #(.EARLY_EXIT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b),
    .sh_data(sh_data1), .sh_sel(sh_sel1), .sh_out(sh_out1),
    .busy(busy1), .done(done1), .product(product1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One operation from the IDLE state; called at a falling edge, returns at
  // the falling edge after product updates. exp_seq packs the sh_sel values.
  task automatic run_op(input bit sel, input logic [3:0] av, input logic [3:0] bv,
                        input logic [7:0] exp_p, input int exp_run,
                        input logic [7:0] exp_seq, input string tag);
    int run;
    int n;
    logic [7:0] seq;
    logic [7:0] prev;
    run  = 0;
    n    = 0;
    seq  = '0;
    cur  = sel;
    prev = sel ? last_p1 : last_p0;
    a = av;
    b = bv;
    start0 = !sel;
    start1 = sel;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    a = ~av;
    b = ~bv;
    check({tag, "_sh_data"}, c_data, av);
    check({tag, "_hold"}, c_prod, prev);
    while (!c_done && n < 20) begin
      if (c_busy) begin
        run++;
        seq = {seq[5:0], c_sel};
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, c_done, 1'b1);
    check({tag, "_runs"}, run, exp_run);
    check({tag, "_sel_seq"}, seq, exp_seq);
    check({tag, "_busy_in_done"}, c_busy, 1'b1);
    @(negedge clk);
    check({tag, "_product"}, c_prod, exp_p);
    check({tag, "_idle"}, {c_busy, c_done, c_sel, c_data}, 8'd0);
    if (sel) last_p1 = exp_p; else last_p0 = exp_p;
  endtask

  initial begin
    int n;
    int pulses;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_out0", {busy0, done0, sh_sel0, sh_data0, product0}, 16'd0);
    check("rst_out1", {busy1, done1, sh_sel1, sh_data1, product1}, 16'd0);

    // EARLY_EXIT=0: always four RUN cycles, sh_sel 0,1,2,3 -> 8'h1B.
    run_op(1'b0, 4'd15, 4'd15, 8'd225, 4, 8'h1B, "e0_15x15");
    run_op(1'b0, 4'd9,  4'd6,  8'd54,  4, 8'h1B, "e0_9x6");
    run_op(1'b0, 4'd0,  4'd13, 8'd0,   4, 8'h1B, "e0_0x13");
    run_op(1'b0, 4'd11, 4'd0,  8'd0,   4, 8'h1B, "e0_11x0");

    // EARLY_EXIT=1: RUN cycles = highest set bit index + 1, minimum one.
    run_op(1'b1, 4'd5,  4'h1, 8'd5,   1, 8'h00, "e1_5x1");
    run_op(1'b1, 4'd7,  4'h4, 8'd28,  3, 8'h06, "e1_7x4");
    run_op(1'b1, 4'd9,  4'h0, 8'd0,   1, 8'h00, "e1_9x0");
    run_op(1'b1, 4'd15, 4'h8, 8'd120, 4, 8'h1B, "e1_15x8");

    // start held for ten cycles; operands change during the first run.
    cur = 1'b0;
    a = 4'd3;
    b = 4'd5;
    start0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a = 4'd2;
        b = 4'd2;
      end
      if (i == 3) check("held_no_done_early", done0, 1'b0);
      if (i == 4) check("held_done1", done0, 1'b1);
      if (i == 5) begin
        check("held_product1", product0, 8'd15);
        check("held_idle", busy0, 1'b0);
      end
      if (i == 6) check("held_restart", busy0, 1'b1);
    end
    start0 = 1'b0;
    n = 0;
    while (!done0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("held_done2", done0, 1'b1);
    @(negedge clk);
    check("held_product2", product0, 8'd4);
    check("held_no_third", busy0, 1'b0);
    last_p0 = 8'd4;

    // Reset in the middle of a run (cnt=2) of 15x15.
    a = 4'd15;
    b = 4'd15;
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_sel_k2", sh_sel0, 2'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_busy", busy0, 1'b0);
    check("mid_rst_product", product0, 8'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done0) pulses++;
      @(negedge clk);
    end
    check("mid_rst_no_done", pulses, 0);
    last_p0 = 8'd0;
    last_p1 = 8'd0;
    run_op(1'b0, 4'd2, 4'd3, 8'd6, 4, 8'h1B, "after_rst_2x3");

    // Back-to-back: 25 must hold through the second run until its DONE.
    run_op(1'b0, 4'd5, 4'd5, 8'd25, 4, 8'h1B, "b2b_5x5");
    run_op(1'b0, 4'd1, 4'd1, 8'd1,  4, 8'h1B, "b2b_1x1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
